mp_ooo_2_port_sram_ctrl: RTL and testbench

//  Parametrised 2-port RW SRAM model/controller for mp_ooo tables (predictor counters, scoreboards).

---
 rtl/mp_ooo_sram_pkg.sv | 25 ++
 rtl/mp_ooo_sram_clr_fsm.sv | 56 +++++
 rtl/mp_ooo_2_port_sram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mp_ooo_2_port_sram_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_ooo_sram_pkg.sv
// Shared definitions for the mp_ooo 2-port SRAM controller: FSM state codes,
// address-width helper and the lane-merge function used for write forwarding.
package mp_ooo_sram_pkg;

    typedef logic [0:0] sram_state_t;

    localparam sram_state_t ST_INIT  = 1'b0;
    localparam sram_state_t ST_READY = 1'b1;

    // Widest entry the merge helper can carry; callers size-cast in and out.
    localparam int MAX_DATA_WIDTH = 256;

    typedef logic [MAX_DATA_WIDTH-1:0] wide_word_t;

    function automatic int calc_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic wide_word_t lane_merge(input wide_word_t old_word,
                                              input wide_word_t new_word,
                                              input wide_word_t bit_en);
        return (old_word & ~bit_en) | (new_word & bit_en);
    endfunction

endpackage

// File: rtl/mp_ooo_sram_clr_fsm.sv
// Post-reset / on-demand array clear sequencer: walks every entry once,
// then holds READY until init_start requests another sweep.
module mp_ooo_sram_clr_fsm
    import mp_ooo_sram_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    sram_state_t           state_reg;
    sram_state_t           state_next;
    logic [ADDR_WIDTH-1:0] clr_ptr_reg;
    logic [ADDR_WIDTH-1:0] clr_ptr_next;

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        if (state_reg == ST_INIT) begin
            if (clr_ptr_reg == LAST_PTR) begin
                state_next   = ST_READY;
                clr_ptr_next = '0;
            end else begin
                clr_ptr_next = clr_ptr_reg + 1'b1;
            end
        end else if (init_start) begin
            state_next   = ST_INIT;
            clr_ptr_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_INIT;
            clr_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
        end
    end

    assign init_busy = (state_reg == ST_INIT);
    assign ready     = (state_reg == ST_READY);
    assign clr_we    = init_busy;
    assign clr_addr  = clr_ptr_reg;

endmodule

// File: rtl/mp_ooo_2_port_sram_ctrl.sv
// Parametrised 2-port RW SRAM with lane write masks, port-0-wins collision rule,
// auto-clear and collision counter. Define WRITE_FORWARD_EN for write-to-read forwarding.
module mp_ooo_2_port_sram_ctrl
    import mp_ooo_sram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 2,
    parameter int                    DEPTH      = 512,
    parameter int                    MASK_GRAN  = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    CNT_WIDTH  = 16,
    localparam int                   ADDR_WIDTH = calc_addr_width(DEPTH),
    localparam int                   NLANES     = DATA_WIDTH / MASK_GRAN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_start,
    output logic                  init_busy,
    input  logic                  req_valid0,
    output logic                  req_ready0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [NLANES-1:0]     wmask0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  rsp_valid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req_valid1,
    output logic                  req_ready1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [NLANES-1:0]     wmask1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  rsp_valid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [CNT_WIDTH-1:0]  coll_cnt
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic                  req_valid_a [2];
    logic                  we_a        [2];
    logic [ADDR_WIDTH-1:0] addr_a      [2];
    logic [NLANES-1:0]     wmask_a     [2];
    logic [DATA_WIDTH-1:0] wdata_a     [2];

    logic [1:0] acc;
    logic [1:0] in_range;
    logic [1:0] wr_en;
    logic [1:0] rd_en;
    logic       coll_hit;

    logic [CNT_WIDTH-1:0] coll_cnt_reg;

    assign req_valid_a[0] = req_valid0;
    assign req_valid_a[1] = req_valid1;
    assign we_a[0]        = we0;
    assign we_a[1]        = we1;
    assign addr_a[0]      = addr0;
    assign addr_a[1]      = addr1;
    assign wmask_a[0]     = wmask0;
    assign wmask_a[1]     = wmask1;
    assign wdata_a[0]     = wdata0;
    assign wdata_a[1]     = wdata1;

    mp_ooo_sram_clr_fsm #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_start (init_start),
        .init_busy  (init_busy),
        .ready      (ready),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr)
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic                  rsp_valid_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic [DATA_WIDTH-1:0] mem_word;
            logic [DATA_WIDTH-1:0] rd_word;

            assign acc[gi]      = req_valid_a[gi] && ready;
            assign in_range[gi] = ({1'b0, addr_a[gi]} < DEPTH_W);
            assign wr_en[gi]    = acc[gi] && we_a[gi] && in_range[gi];
            assign rd_en[gi]    = acc[gi] && !we_a[gi];

            // Out-of-range reads still respond, with zero data.
            assign mem_word = in_range[gi] ? mem[addr_a[gi]] : '0;

`ifdef WRITE_FORWARD_EN
            logic [DATA_WIDTH-1:0] bit_en;

            for (genvar li = 0; li < NLANES; li++) begin : g_lane
                assign bit_en[li*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wmask_a[1-gi][li]}};
            end

            // The other port's write lands at the same edge; present its merged result.
            assign rd_word = (wr_en[1-gi] && (addr_a[1-gi] == addr_a[gi]))
                           ? DATA_WIDTH'(lane_merge(wide_word_t'(mem_word),
                                                    wide_word_t'(wdata_a[1-gi]),
                                                    wide_word_t'(bit_en)))
                           : mem_word;
`else
            assign rd_word = mem_word;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rsp_valid_reg <= 1'b0;
                    rdata_reg     <= '0;
                end else begin
                    rsp_valid_reg <= rd_en[gi];
                    if (rd_en[gi]) begin
                        rdata_reg <= rd_word;
                    end
                end
            end
        end
    endgenerate

    // Lane writes are issued port 1 first so port 0 overrides on shared lanes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VALUE;
        end else begin
            for (int li = 0; li < NLANES; li++) begin
                if (wr_en[1] && wmask_a[1][li]) begin
                    mem[addr_a[1]][li*MASK_GRAN +: MASK_GRAN] <= wdata_a[1][li*MASK_GRAN +: MASK_GRAN];
                end
                if (wr_en[0] && wmask_a[0][li]) begin
                    mem[addr_a[0]][li*MASK_GRAN +: MASK_GRAN] <= wdata_a[0][li*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    assign coll_hit = acc[0] && acc[1] && (addr_a[0] == addr_a[1]) && in_range[0]
                    && (we_a[0] || we_a[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt_reg <= '0;
        end else if (coll_hit && (coll_cnt_reg != '1)) begin
            coll_cnt_reg <= coll_cnt_reg + 1'b1;
        end
    end

    assign req_ready0 = ready;
    assign req_ready1 = ready;
    assign rsp_valid0 = g_port[0].rsp_valid_reg;
    assign rsp_valid1 = g_port[1].rsp_valid_reg;
    assign rdata0     = g_port[0].rdata_reg;
    assign rdata1     = g_port[1].rdata_reg;
    assign coll_cnt   = coll_cnt_reg;

endmodule

// File: tb/tb_mp_ooo_2_port_sram_ctrl.sv
// Randomised bench for mp_ooo_2_port_sram_ctrl (8-bit entries, 12 deep, 4-bit lanes)
// against a behavioural array model; honours WRITE_FORWARD_EN.
module tb_mp_ooo_2_port_sram_ctrl;

    localparam int        DW    = 8;
    localparam int        DEP   = 12;
    localparam logic [7:0] INITV = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_start;
    logic        init_busy;
    logic        req_ready0, req_ready1;
    logic        rsp_valid0, rsp_valid1;
    logic [7:0]  rdata0, rdata1;
    logic [15:0] coll_cnt;

    logic        t_valid [2];
    logic        t_we    [2];
    logic [3:0]  t_addr  [2];
    logic [1:0]  t_mask  [2];
    logic [7:0]  t_data  [2];

    logic [7:0]  m_mem [DEP];
    logic [7:0]  m_rd  [2];
    logic        m_rv  [2];
    logic [15:0] m_coll;
    int          m_busy;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    mp_ooo_2_port_sram_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .MASK_GRAN  (4),
        .INIT_VALUE (INITV),
        .CNT_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_start (init_start),
        .init_busy  (init_busy),
        .req_valid0 (t_valid[0]),
        .req_ready0 (req_ready0),
        .we0        (t_we[0]),
        .addr0      (t_addr[0]),
        .wmask0     (t_mask[0]),
        .wdata0     (t_data[0]),
        .rsp_valid0 (rsp_valid0),
        .rdata0     (rdata0),
        .req_valid1 (t_valid[1]),
        .req_ready1 (req_ready1),
        .we1        (t_we[1]),
        .addr1      (t_addr[1]),
        .wmask1     (t_mask[1]),
        .wdata1     (t_data[1]),
        .rsp_valid1 (rsp_valid1),
        .rdata1     (rdata1),
        .coll_cnt   (coll_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] apply_mask(input logic [7:0] old_v, input logic [7:0] new_v,
                                              input logic [1:0] m);
        logic [7:0] r;
        r = old_v;
        if (m[0]) r[3:0] = new_v[3:0];
        if (m[1]) r[7:4] = new_v[7:4];
        return r;
    endfunction

    task automatic set_idle();
        init_start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            t_valid[p] = 1'b0;
            t_we[p]    = 1'b0;
            t_addr[p]  = '0;
            t_mask[p]  = '0;
            t_data[p]  = '0;
        end
    endtask

    task automatic issue(input int p, input logic w, input logic [3:0] a,
                         input logic [1:0] m, input logic [7:0] d);
        t_valid[p] = 1'b1;
        t_we[p]    = w;
        t_addr[p]  = a;
        t_mask[p]  = m;
        t_data[p]  = d;
    endtask

    task automatic model_reset();
        m_busy = DEP;
        m_coll = '0;
        for (int p = 0; p < 2; p++) begin
            m_rd[p] = '0;
            m_rv[p] = 1'b0;
        end
        for (int i = 0; i < DEP; i++) m_mem[i] = INITV;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_busy"},  {31'd0, init_busy},  {31'd0, m_busy > 0});
        chk({tag, "_rdy0"},  {31'd0, req_ready0}, {31'd0, m_busy == 0});
        chk({tag, "_rdy1"},  {31'd0, req_ready1}, {31'd0, m_busy == 0});
        chk({tag, "_rv0"},   {31'd0, rsp_valid0}, {31'd0, m_rv[0]});
        chk({tag, "_rv1"},   {31'd0, rsp_valid1}, {31'd0, m_rv[1]});
        chk({tag, "_rd0"},   {24'd0, rdata0},     {24'd0, m_rd[0]});
        chk({tag, "_rd1"},   {24'd0, rdata1},     {24'd0, m_rd[1]});
        chk({tag, "_coll"},  {16'd0, coll_cnt},   {16'd0, m_coll});
    endtask

    // One clock of the reference model followed by a check of every output.
    task automatic do_cycle(input string tag);
        logic       rdy;
        logic       acc [2];
        logic [7:0] snap [DEP];
        logic [7:0] v;
        int         q;
        rdy = (m_busy == 0);
        for (int p = 0; p < 2; p++) acc[p] = t_valid[p] && rdy;
        snap = m_mem;
        for (int p = 0; p < 2; p++) begin
            m_rv[p] = acc[p] && !t_we[p];
            if (m_rv[p]) begin
                q = 1 - p;
                v = (t_addr[p] < DEP) ? snap[t_addr[p]] : 8'h00;
`ifdef WRITE_FORWARD_EN
                if (acc[q] && t_we[q] && t_addr[q] == t_addr[p] && t_addr[p] < DEP)
                    v = apply_mask(v, t_data[q], t_mask[q]);
`endif
                m_rd[p] = v;
            end
        end
        if (acc[0] && acc[1] && t_addr[0] == t_addr[1] && t_addr[0] < DEP
            && (t_we[0] || t_we[1]) && m_coll != 16'hFFFF)
            m_coll = m_coll + 16'd1;
        for (int p = 1; p >= 0; p--) begin
            if (acc[p] && t_we[p] && t_addr[p] < DEP)
                m_mem[t_addr[p]] = apply_mask(m_mem[t_addr[p]], t_data[p], t_mask[p]);
        end
        if (rdy && init_start) begin
            m_busy = DEP;
            for (int i = 0; i < DEP; i++) m_mem[i] = INITV;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic release_and_clear(input string tag);
        rst_n = 1'b1;
        chk({tag, "_busy_at_release"}, {31'd0, init_busy}, 32'd1);
        for (int i = 0; i < DEP; i++) do_cycle(tag);
        chk({tag, "_busy_done"}, {31'd0, init_busy}, 32'd0);
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        release_and_clear("init");

        issue(0, 1'b0, 4'd11, 2'b00, 8'h00);
        do_cycle("rd11");
        chk("rd11_val", {24'd0, rdata0}, 32'hA5);
        set_idle();

        issue(0, 1'b1, 4'd3, 2'b11, 8'h12);
        issue(1, 1'b1, 4'd3, 2'b10, 8'h34);
        do_cycle("ww3");
        set_idle();
        issue(0, 1'b0, 4'd3, 2'b00, 8'h00);
        do_cycle("rd3");
        chk("ww3_val", {24'd0, rdata0}, 32'h12);
        chk("ww3_coll", {16'd0, coll_cnt}, 32'd1);
        set_idle();

        issue(0, 1'b1, 4'd5, 2'b01, 8'hF0);
        do_cycle("wr5");
        set_idle();
        issue(0, 1'b0, 4'd5, 2'b00, 8'h00);
        do_cycle("rd5");
        chk("mask5_val", {24'd0, rdata0}, 32'hA0);
        set_idle();

        issue(0, 1'b1, 4'd2, 2'b11, 8'h77);
        issue(1, 1'b0, 4'd2, 2'b00, 8'h00);
        do_cycle("wr2");
`ifdef WRITE_FORWARD_EN
        chk("fwd2_val", {24'd0, rdata1}, 32'h77);
`else
        chk("fwd2_val", {24'd0, rdata1}, 32'hA5);
`endif
        chk("fwd2_coll", {16'd0, coll_cnt}, 32'd2);
        set_idle();

        issue(0, 1'b0, 4'd13, 2'b00, 8'h00);
        do_cycle("rd13");
        chk("rd13_rv", {31'd0, rsp_valid0}, 32'd1);
        chk("rd13_val", {24'd0, rdata0}, 32'd0);
        set_idle();
        issue(1, 1'b1, 4'd14, 2'b11, 8'hFF);
        issue(0, 1'b1, 4'd14, 2'b11, 8'hEE);
        do_cycle("wr14");
        set_idle();

        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < 2; p++) begin
                t_valid[p] = ($urandom_range(0, 3) != 0);
                t_we[p]    = $urandom_range(0, 1) == 1;
                t_addr[p]  = 4'($urandom_range(0, 15));
                t_mask[p]  = 2'($urandom_range(0, 3));
                t_data[p]  = 8'($urandom);
            end
            if ($urandom_range(0, 2) == 0) t_addr[1] = t_addr[0];
            init_start = ($urandom_range(0, 59) == 0);
            do_cycle("rand");
        end
        set_idle();

        for (int i = 0; i < 20 && m_busy > 0; i++) do_cycle("drain");
        chk("drain_ready", {31'd0, req_ready0}, 32'd1);

        issue(0, 1'b1, 4'd3, 2'b11, 8'h5A);
        do_cycle("pre_wr3");
        set_idle();
        issue(0, 1'b0, 4'd3, 2'b00, 8'h00);
        init_start = 1'b1;
        do_cycle("reinit");
        chk("reinit_rd", {24'd0, rdata0}, 32'h5A);
        set_idle();
        for (int i = 0; i < 6; i++) do_cycle("clr");
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("mid_init_rst");
        @(posedge clk);
        #1;
        release_and_clear("reclear");

        issue(1, 1'b0, 4'd4, 2'b00, 8'h00);
        #4;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("pend_rst");
        @(posedge clk);
        #1;
        check_outputs("pend_rst_edge");
        set_idle();
        release_and_clear("reclear2");
        issue(1, 1'b0, 4'd3, 2'b00, 8'h00);
        do_cycle("post_rd3");
        chk("post_rd3_val", {24'd0, rdata1}, 32'hA5);
        set_idle();
        do_cycle("tail");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
